// File: rtl/fifo_async_pkg.sv
// Shared async-FIFO package: default geometry and Gray/binary conversion helpers,
// used by both the write-side and read-side pointer blocks.
package fifo_async_pkg;

  localparam int ADDRESS_SIZE = 4;
  localparam int DEPTH        = 2 ** ADDRESS_SIZE;
  localparam int PTR_W        = ADDRESS_SIZE + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray converter.
module binary_to_gray
  import fifo_async_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  logic [31:0] conv;

  assign conv = bin2gray(32'(bin));
  assign gray = conv[W-1:0];

endmodule

// File: rtl/d_ff_async.sv
// Generic W-bit register with asynchronous active-high reset to zero.
module d_ff_async #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter.
module gray_to_binary
  import fifo_async_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  logic [31:0] conv;

  assign conv = gray2bin(32'(gray));
  assign bin  = conv[W-1:0];

endmodule

// File: rtl/two_ff_synchronizer.sv
// Two-flop synchroniser for a Gray-coded bus crossing into clk; async active-low clear.
module two_ff_synchronizer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/w_full_gen.sv
// Registered full (and optional almost-full) flag for the write side.
// Almost-full logic is present only when W_ALMOST_FULL_EN is defined.
module w_full_gen #(
  parameter int ADDRESS_SIZE = 4,
  parameter int AF_MARGIN    = 2
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic [ADDRESS_SIZE:0] w_gnext,
  input  logic [ADDRESS_SIZE:0] wq2_rptr,
`ifdef W_ALMOST_FULL_EN
  input  logic [ADDRESS_SIZE:0] w_bnext,
  output logic                  w_almost_full,
`endif
  output logic                  w_full
);

  localparam int AS = ADDRESS_SIZE;

  // Full when the next write pointer equals the read pointer with the top two Gray bits inverted.
  logic [AS:0] full_cmp;

  assign full_cmp = {~wq2_rptr[AS:AS-1], wq2_rptr[AS-2:0]};

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_full <= 1'b0;
    end else begin
      w_full <= (w_gnext == full_cmp);
    end
  end

`ifdef W_ALMOST_FULL_EN
  localparam logic [AS:0] AF_LEVEL = (AS+1)'((2 ** AS) - AF_MARGIN);

  logic [AS:0] rq_bin;
  logic [AS:0] fill;

  gray_to_binary #(.W(AS + 1)) u_rq_g2b (
    .gray (wq2_rptr),
    .bin  (rq_bin)
  );

  assign fill = w_bnext - rq_bin;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_almost_full <= 1'b0;
    end else begin
      w_almost_full <= (fill >= AF_LEVEL);
    end
  end
`endif

endmodule

// File: rtl/w_clk_module_1.sv
// Write-clock-domain half of the async FIFO: write pointer, RAM address, reader-pointer sync, full flag.
// Define W_ALMOST_FULL_EN to add the w_almost_full output.
module w_clk_module_1 #(
  parameter int ADDRESS_SIZE = 4,
  parameter int AF_MARGIN    = 2
) (
  input  logic                    w_clk,
  input  logic                    w_rst,
  input  logic                    w_en,
  input  logic [ADDRESS_SIZE:0]   r_ptr,
  output logic                    w_full,
  output logic [ADDRESS_SIZE:0]   w_ptr,
`ifdef W_ALMOST_FULL_EN
  output logic                    w_almost_full,
`endif
  output logic [ADDRESS_SIZE-1:0] w_addr
);

  localparam int PW = ADDRESS_SIZE + 1;

  logic          w_inc;
  logic [PW-1:0] w_bin;
  logic [PW-1:0] w_bnext;
  logic [PW-1:0] w_gnext;
  logic [PW-1:0] wq2_rptr;
  logic          sync_rst_n;

  // Writes presented while full are dropped here, so nothing downstream moves.
  assign w_inc      = w_en & ~w_full;
  assign w_bnext    = w_bin + PW'(w_inc);
  assign w_addr     = w_bin[ADDRESS_SIZE-1:0];
  assign sync_rst_n = ~w_rst;

  binary_to_gray #(.W(PW)) u_b2g (
    .bin  (w_bnext),
    .gray (w_gnext)
  );

  d_ff_async #(.W(PW)) u_bin_reg (
    .clk (w_clk),
    .rst (w_rst),
    .d   (w_bnext),
    .q   (w_bin)
  );

  d_ff_async #(.W(PW)) u_ptr_reg (
    .clk (w_clk),
    .rst (w_rst),
    .d   (w_gnext),
    .q   (w_ptr)
  );

  two_ff_synchronizer #(.W(PW)) u_rptr_sync (
    .clk   (w_clk),
    .rst_n (sync_rst_n),
    .d     (r_ptr),
    .q     (wq2_rptr)
  );

  w_full_gen #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .AF_MARGIN    (AF_MARGIN)
  ) u_full_gen (
    .w_clk         (w_clk),
    .w_rst         (w_rst),
    .w_gnext       (w_gnext),
    .wq2_rptr      (wq2_rptr),
`ifdef W_ALMOST_FULL_EN
    .w_bnext       (w_bnext),
    .w_almost_full (w_almost_full),
`endif
    .w_full        (w_full)
  );

endmodule

// File: tb/tb_w_clk_module_1.sv
// Directed bench for w_clk_module_1 at ADDRESS_SIZE=2 (depth 4), AF_MARGIN=1.
// Almost-full checks run only when W_ALMOST_FULL_EN is defined.
module tb_w_clk_module_1;

  logic       w_clk = 1'b0;
  logic       w_rst = 1'b1;
  logic       w_en  = 1'b0;
  logic [2:0] r_ptr = 3'd0;
  logic       w_full;
  logic [2:0] w_ptr;
  logic [1:0] w_addr;
`ifdef W_ALMOST_FULL_EN
  logic       w_almost_full;
`endif

  int checks   = 0;
  int failures = 0;

  logic [2:0] gray_seq [8] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
  logic [1:0] addr_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [2:0] hist [16];

  w_clk_module_1 #(
    .ADDRESS_SIZE (2),
    .AF_MARGIN    (1)
  ) dut (
    .w_clk         (w_clk),
    .w_rst         (w_rst),
    .w_en          (w_en),
    .r_ptr         (r_ptr),
    .w_full        (w_full),
    .w_ptr         (w_ptr),
`ifdef W_ALMOST_FULL_EN
    .w_almost_full (w_almost_full),
`endif
    .w_addr        (w_addr)
  );

  always #5 w_clk = ~w_clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic en, input logic [2:0] rp);
    @(negedge w_clk);
    w_en  = en;
    r_ptr = rp;
    @(posedge w_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge w_clk);
    w_rst = 1'b1;
    w_en  = 1'b0;
    r_ptr = 3'd0;
    @(negedge w_clk);
    w_rst = 1'b0;
  endtask

  initial begin
    // Test 1: reset values, then fill the FIFO with four writes
    #2;
    checkOutput("reset_ptr", 32'(w_ptr), 32'd0);
    checkOutput("reset_addr", 32'(w_addr), 32'd0);
    checkOutput("reset_full", 32'(w_full), 32'd0);
`ifdef W_ALMOST_FULL_EN
    checkOutput("reset_af", 32'(w_almost_full), 32'd0);
`endif
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd0);
      checkOutput($sformatf("fill_ptr%0d", i), 32'(w_ptr), 32'(gray_seq[i]));
      checkOutput($sformatf("fill_addr%0d", i), 32'(w_addr), 32'(addr_seq[i]));
      checkOutput($sformatf("fill_full%0d", i), 32'(w_full), (i == 3) ? 32'd1 : 32'd0);
`ifdef W_ALMOST_FULL_EN
      checkOutput($sformatf("fill_af%0d", i), 32'(w_almost_full), (i >= 2) ? 32'd1 : 32'd0);
`endif
    end

    // Test 2: writes while full are ignored
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd0);
      checkOutput($sformatf("held_ptr%0d", i), 32'(w_ptr), 32'd6);
      checkOutput($sformatf("held_addr%0d", i), 32'(w_addr), 32'd0);
      checkOutput($sformatf("held_full%0d", i), 32'(w_full), 32'd1);
    end

    // Test 3: one read releases full on the third edge; next write refills
    applyStimulus(1'b0, 3'd1);
    checkOutput("release_e1", 32'(w_full), 32'd1);
    applyStimulus(1'b0, 3'd1);
    checkOutput("release_e2", 32'(w_full), 32'd1);
    applyStimulus(1'b0, 3'd1);
    checkOutput("release_e3", 32'(w_full), 32'd0);
    applyStimulus(1'b1, 3'd1);
    checkOutput("refill_ptr", 32'(w_ptr), 32'd7);
    checkOutput("refill_addr", 32'(w_addr), 32'd1);
    checkOutput("refill_full", 32'(w_full), 32'd1);

    // Test 4: wrap with reader tracking two steps behind
    doReset();
    begin
      int widx;
      logic [2:0] cur;
      widx = 0;
      cur  = 3'd0;
      for (int k = 0; k < 16; k++) begin
        applyStimulus((k % 2) == 0, (k >= 2) ? hist[k-2] : 3'd0);
        if ((k % 2) == 0) begin
          cur = gray_seq[widx];
          widx++;
        end
        hist[k] = cur;
        checkOutput($sformatf("wrap_ptr%0d", k), 32'(w_ptr), 32'(cur));
        checkOutput($sformatf("wrap_full%0d", k), 32'(w_full), 32'd0);
      end
    end

    // Test 5: asynchronous reset mid-stream
    doReset();
    applyStimulus(1'b1, 3'd0);
    applyStimulus(1'b1, 3'd0);
    checkOutput("pre_rst_ptr", 32'(w_ptr), 32'd3);
    w_en = 1'b0;
    #2;
    w_rst = 1'b1;
    #1;
    checkOutput("async_rst_ptr", 32'(w_ptr), 32'd0);
    checkOutput("async_rst_addr", 32'(w_addr), 32'd0);
    checkOutput("async_rst_full", 32'(w_full), 32'd0);
`ifdef W_ALMOST_FULL_EN
    checkOutput("async_rst_af", 32'(w_almost_full), 32'd0);
`endif
    @(negedge w_clk);
    w_rst = 1'b0;
    applyStimulus(1'b1, 3'd0);
    checkOutput("post_rst_ptr", 32'(w_ptr), 32'd1);
    checkOutput("post_rst_addr", 32'(w_addr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
